// File: rtl/wb_arbiter_pkg.sv
// Shared widths and writeback grant-select encodings for the integer register file write path.
package wb_arbiter_pkg;

    localparam int CPU_WIDTH      = 64;
    localparam int REG_ADDR_WIDTH = 5;
    localparam int REG_DATA_DEPTH = 32;

    localparam logic [1:0] WB_SRC_LD  = 2'd0;
    localparam logic [1:0] WB_SRC_CSR = 2'd1;
    localparam logic [1:0] WB_SRC_ALU = 2'd2;

    typedef enum logic [1:0] {
        SRC_LD   = WB_SRC_LD,
        SRC_CSR  = WB_SRC_CSR,
        SRC_ALU  = WB_SRC_ALU,
        SRC_NONE = 2'd3
    } wb_src_e;

endpackage

// File: rtl/wb_scoreboard.sv
// Outstanding-load scoreboard: busy bit per register, sticky protocol error, decode read lookups.
// Latency: busy/err update at the clock edge; lookups are combinational.
// Backpressure: none; issues and responses are always absorbed.
module wb_scoreboard
    import wb_arbiter_pkg::*;
#(
    parameter int NREG = REG_DATA_DEPTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      ld_issue_vld_i,
    input  logic [REG_ADDR_WIDTH-1:0] ld_issue_rd_i,
    input  logic                      ld_rsp_vld_i,
    input  logic [REG_ADDR_WIDTH-1:0] ld_rsp_rd_i,
    input  logic [REG_ADDR_WIDTH-1:0] rd1_addr_i,
    input  logic [REG_ADDR_WIDTH-1:0] rd2_addr_i,
    output logic [NREG-1:0]           busy_o,
    output logic                      rd1_busy_o,
    output logic                      rd2_busy_o,
    output logic                      sb_err_o
);

    logic [NREG-1:0] busy_q, busy_d;
    logic            err_q, err_d;
    logic            issue_live;

    assign issue_live = ld_issue_vld_i && (ld_issue_rd_i != '0);

    always_comb begin
        busy_d = busy_q;
        // Clear before set so a same-cycle reissue leaves the register outstanding.
        if (ld_rsp_vld_i) busy_d[ld_rsp_rd_i] = 1'b0;
        if (issue_live)   busy_d[ld_issue_rd_i] = 1'b1;
        busy_d[0] = 1'b0;

        err_d = err_q
              | (issue_live && busy_q[ld_issue_rd_i])
              | (ld_rsp_vld_i && !busy_q[ld_rsp_rd_i]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
            err_q  <= 1'b0;
        end else begin
            busy_q <= busy_d;
            err_q  <= err_d;
        end
    end

    assign busy_o     = busy_q;
    assign rd1_busy_o = busy_q[rd1_addr_i];
    assign rd2_busy_o = busy_q[rd2_addr_i];
    assign sb_err_o   = err_q;

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: load > CSR > ALU onto one register-file write port, with ALU anti-starvation.
// Latency: grant in cycle N appears on reg_wen/waddr/wdata in cycle N+1; one write per cycle.
// Backpressure: combinational csr_ready/alu_ready; held low behind a load response or a pending load to the same rd.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int XLEN       = CPU_WIDTH,
    parameter int NREG       = REG_DATA_DEPTH,
    parameter int STARVE_MAX = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      ld_rsp_valid,
    input  logic [REG_ADDR_WIDTH-1:0] ld_rsp_rd,
    input  logic [XLEN-1:0]           ld_rsp_data,
    input  logic                      ld_issue_valid,
    input  logic [REG_ADDR_WIDTH-1:0] ld_issue_rd,
    input  logic                      csr_valid,
    output logic                      csr_ready,
    input  logic [REG_ADDR_WIDTH-1:0] csr_waddr,
    input  logic [XLEN-1:0]           csr_wdata,
    input  logic                      alu_valid,
    output logic                      alu_ready,
    input  logic [REG_ADDR_WIDTH-1:0] alu_waddr,
    input  logic [XLEN-1:0]           alu_wdata,
    input  logic [REG_ADDR_WIDTH-1:0] reg1_raddr,
    input  logic [REG_ADDR_WIDTH-1:0] reg2_raddr,
    output logic                      hazard,
    output logic                      reg_wen,
    output logic [REG_ADDR_WIDTH-1:0] reg_waddr,
    output logic [XLEN-1:0]           reg_wdata,
    output logic                      sb_err
);

    localparam int SW = $clog2(STARVE_MAX + 1);

    logic [NREG-1:0]           busy;
    logic                      rd1_busy, rd2_busy;
    logic [SW-1:0]             starve_q, starve_d;
    logic                      promote, csr_go, alu_go;
    wb_src_e                   grant;
    logic [REG_ADDR_WIDTH-1:0] wr_addr;
    logic [XLEN-1:0]           wr_data;
    logic                      wen_q;
    logic [REG_ADDR_WIDTH-1:0] waddr_q;
    logic [XLEN-1:0]           wdata_q;

    wb_scoreboard #(.NREG(NREG)) u_sb (
        .clk            (clk),
        .rst            (rst),
        .ld_issue_vld_i (ld_issue_valid),
        .ld_issue_rd_i  (ld_issue_rd),
        .ld_rsp_vld_i   (ld_rsp_valid),
        .ld_rsp_rd_i    (ld_rsp_rd),
        .rd1_addr_i     (reg1_raddr),
        .rd2_addr_i     (reg2_raddr),
        .busy_o         (busy),
        .rd1_busy_o     (rd1_busy),
        .rd2_busy_o     (rd2_busy),
        .sb_err_o       (sb_err)
    );

    always_comb begin
        promote   = (starve_q == SW'(STARVE_MAX));
        csr_ready = !rst && !ld_rsp_valid && !promote && !busy[csr_waddr];
        alu_ready = !rst && !ld_rsp_valid && !(csr_valid && !promote) && !busy[alu_waddr];
        csr_go    = csr_valid && csr_ready;
        alu_go    = alu_valid && alu_ready;

        grant   = SRC_NONE;
        wr_addr = '0;
        wr_data = '0;
        if (ld_rsp_valid) begin
            grant   = SRC_LD;
            wr_addr = ld_rsp_rd;
            wr_data = ld_rsp_data;
        end else if (csr_go) begin
            grant   = SRC_CSR;
            wr_addr = csr_waddr;
            wr_data = csr_wdata;
        end else if (alu_go) begin
            grant   = SRC_ALU;
            wr_addr = alu_waddr;
            wr_data = alu_wdata;
        end

        // Only a CSR win counts as starvation; waits behind loads or busy rd do not.
        starve_d = starve_q;
        if (!alu_valid || alu_go)
            starve_d = '0;
        else if (csr_go && !promote)
            starve_d = starve_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_q <= '0;
            wen_q    <= 1'b0;
            waddr_q  <= '0;
            wdata_q  <= '0;
        end else begin
            starve_q <= starve_d;
            wen_q    <= (grant != SRC_NONE) && (wr_addr != '0);
            if (grant != SRC_NONE) begin
                waddr_q <= wr_addr;
                wdata_q <= wr_data;
            end
        end
    end

    assign reg_wen   = wen_q;
    assign reg_waddr = waddr_q;
    assign reg_wdata = wdata_q;

    // Staged-write term covers the cycle between the busy clear and the register-file commit.
    assign hazard = rd1_busy | rd2_busy
                  | (wen_q && (waddr_q != '0) && ((waddr_q == reg1_raddr) || (waddr_q == reg2_raddr)));

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: write scoreboard queue, table of ready/hazard vectors, hand sequences for multi-cycle cases.
module tb_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ld_rsp_valid, ld_issue_valid, csr_valid, alu_valid;
    logic [4:0]  ld_rsp_rd, ld_issue_rd, csr_waddr, alu_waddr, reg1_raddr, reg2_raddr;
    logic [63:0] ld_rsp_data, csr_wdata, alu_wdata;
    logic        csr_ready, alu_ready, hazard, reg_wen, sb_err;
    logic [4:0]  reg_waddr;
    logic [63:0] reg_wdata;

    int passed = 0;
    int total  = 0;

    typedef struct packed {
        logic [4:0]  a;
        logic [63:0] d;
    } wr_t;
    wr_t exp_q[$];

    typedef struct {
        logic       ld;
        logic       cv;
        logic [4:0] ca;
        logic       av;
        logic [4:0] aa;
        logic [4:0] r1;
        logic [4:0] r2;
        logic       e_cr;
        logic       e_ar;
        logic       e_hz;
    } vec_t;
    vec_t vt[11];

    wb_arbiter #(.XLEN(64), .NREG(32), .STARVE_MAX(8)) dut (
        .clk            (clk),
        .rst            (rst),
        .ld_rsp_valid   (ld_rsp_valid),
        .ld_rsp_rd      (ld_rsp_rd),
        .ld_rsp_data    (ld_rsp_data),
        .ld_issue_valid (ld_issue_valid),
        .ld_issue_rd    (ld_issue_rd),
        .csr_valid      (csr_valid),
        .csr_ready      (csr_ready),
        .csr_waddr      (csr_waddr),
        .csr_wdata      (csr_wdata),
        .alu_valid      (alu_valid),
        .alu_ready      (alu_ready),
        .alu_waddr      (alu_waddr),
        .alu_wdata      (alu_wdata),
        .reg1_raddr     (reg1_raddr),
        .reg2_raddr     (reg2_raddr),
        .hazard         (hazard),
        .reg_wen        (reg_wen),
        .reg_waddr      (reg_waddr),
        .reg_wdata      (reg_wdata),
        .sb_err         (sb_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        else passed++;
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic drop_valids();
        ld_rsp_valid   = 1'b0;
        ld_issue_valid = 1'b0;
        csr_valid      = 1'b0;
        alu_valid      = 1'b0;
    endtask

    task automatic push(input logic [4:0] a, input logic [63:0] d);
        wr_t w;
        w.a = a;
        w.d = d;
        exp_q.push_back(w);
    endtask

    // Every committed write is matched in order against what the stimulus expected to be granted.
    always @(negedge clk) begin : wr_mon
        wr_t e;
        if (reg_wen === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                $display("FAIL wr_unexpected: got write x%0d=0x%0h, expected no write", reg_waddr, reg_wdata);
            end else begin
                e = exp_q.pop_front();
                chk("wr_addr", 64'(reg_waddr), 64'(e.a));
                chk("wr_data", reg_wdata, e.d);
            end
        end
    end

    initial begin
        drop_valids();
        ld_rsp_rd = 0; ld_issue_rd = 0; csr_waddr = 0; alu_waddr = 0;
        ld_rsp_data = 0; csr_wdata = 0; alu_wdata = 0;
        reg1_raddr = 0; reg2_raddr = 0;

        //            ld  cv  ca  av  aa  r1  r2  cr  ar  hz   (x3 busy)
        vt[0]  = '{1'b0, 1'b0, 5'd1, 1'b0, 5'd2, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0};
        vt[1]  = '{1'b1, 1'b1, 5'd1, 1'b1, 5'd2, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0};
        vt[2]  = '{1'b0, 1'b1, 5'd1, 1'b1, 5'd2, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0};
        vt[3]  = '{1'b0, 1'b0, 5'd1, 1'b1, 5'd3, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0};
        vt[4]  = '{1'b0, 1'b1, 5'd3, 1'b1, 5'd2, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0};
        vt[5]  = '{1'b0, 1'b0, 5'd3, 1'b1, 5'd4, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0};
        vt[6]  = '{1'b0, 1'b0, 5'd1, 1'b0, 5'd2, 5'd3, 5'd0, 1'b1, 1'b1, 1'b1};
        vt[7]  = '{1'b0, 1'b0, 5'd1, 1'b0, 5'd2, 5'd0, 5'd3, 1'b1, 1'b1, 1'b1};
        vt[8]  = '{1'b0, 1'b0, 5'd1, 1'b0, 5'd2, 5'd4, 5'd5, 1'b1, 1'b1, 1'b0};
        vt[9]  = '{1'b0, 1'b0, 5'd1, 1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0};
        vt[10] = '{1'b1, 1'b0, 5'd1, 1'b0, 5'd2, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0};

        // Reset state, with requesters valid to show readies are forced low.
        nxt();
        csr_valid = 1; csr_waddr = 6; alu_valid = 1; alu_waddr = 7;
        smp();
        chk("rst_csr_ready", 64'(csr_ready), 0);
        chk("rst_alu_ready", 64'(alu_ready), 0);
        chk("rst_reg_wen",   64'(reg_wen), 0);
        chk("rst_reg_waddr", 64'(reg_waddr), 0);
        chk("rst_reg_wdata", reg_wdata, 0);
        chk("rst_sb_err",    64'(sb_err), 0);
        chk("rst_hazard",    64'(hazard), 0);

        // Three-way collision.
        nxt();
        rst = 0; drop_valids();
        ld_issue_valid = 1; ld_issue_rd = 5;
        smp();
        nxt();
        ld_issue_valid = 0;
        ld_rsp_valid = 1; ld_rsp_rd = 5; ld_rsp_data = 64'h11;
        csr_valid = 1; csr_waddr = 6; csr_wdata = 64'h22;
        alu_valid = 1; alu_waddr = 7; alu_wdata = 64'h33;
        push(5, 64'h11); push(6, 64'h22); push(7, 64'h33);
        smp();
        chk("col_c0_csr_ready", 64'(csr_ready), 0);
        chk("col_c0_alu_ready", 64'(alu_ready), 0);
        nxt();
        ld_rsp_valid = 0;
        smp();
        chk("col_c1_waddr", 64'(reg_waddr), 5);
        chk("col_c1_csr_ready", 64'(csr_ready), 1);
        chk("col_c1_alu_ready", 64'(alu_ready), 0);
        nxt();
        csr_valid = 0;
        smp();
        chk("col_c2_waddr", 64'(reg_waddr), 6);
        chk("col_c2_alu_ready", 64'(alu_ready), 1);
        nxt();
        alu_valid = 0;
        smp();
        chk("col_c3_waddr", 64'(reg_waddr), 7);
        nxt();
        smp();
        chk("col_c4_wen", 64'(reg_wen), 0);

        // Starvation: CSR hammers x9, ALU to x10 is promoted after 8 lost cycles.
        for (int i = 0; i < 10; i++) begin
            nxt();
            csr_valid = 1; csr_waddr = 9; csr_wdata = 64'h100 + 64'((i < 8) ? i : 8);
            alu_valid = (i <= 8); alu_waddr = 10; alu_wdata = 64'hAA;
            if (i < 8)       push(9, 64'h100 + 64'(i));
            else if (i == 8) push(10, 64'hAA);
            else             push(9, 64'h108);
            smp();
            chk($sformatf("stv_c%0d_csr_ready", i), 64'(csr_ready), (i == 8) ? 64'd0 : 64'd1);
            if (i <= 8) chk($sformatf("stv_c%0d_alu_ready", i), 64'(alu_ready), (i == 8) ? 64'd1 : 64'd0);
            if (i == 9) chk("stv_c9_waddr", 64'(reg_waddr), 10);
        end
        nxt();
        drop_valids();
        smp();

        // Load RAW hazard on x3.
        nxt();
        ld_issue_valid = 1; ld_issue_rd = 3;
        smp();
        for (int c = 1; c <= 6; c++) begin
            nxt();
            ld_issue_valid = 0;
            reg1_raddr = 3;
            ld_rsp_valid = (c == 4); ld_rsp_rd = 3; ld_rsp_data = 64'h3333;
            if (c == 4) push(3, 64'h3333);
            smp();
            chk($sformatf("raw_c%0d_hazard", c), 64'(hazard), (c <= 5) ? 64'd1 : 64'd0);
            if (c == 5) begin
                chk("raw_c5_wen", 64'(reg_wen), 1);
                chk("raw_c5_waddr", 64'(reg_waddr), 3);
            end
        end
        nxt();
        reg1_raddr = 0; ld_rsp_valid = 0;
        ld_issue_valid = 1; ld_issue_rd = 3;
        smp();

        // Combinational ready/hazard vectors with x3 outstanding; valids withdrawn before each edge.
        for (int v = 0; v < 11; v++) begin
            nxt();
            ld_issue_valid = 0;
            ld_rsp_valid = vt[v].ld; ld_rsp_rd = 3;
            csr_valid = vt[v].cv; csr_waddr = vt[v].ca;
            alu_valid = vt[v].av; alu_waddr = vt[v].aa;
            reg1_raddr = vt[v].r1; reg2_raddr = vt[v].r2;
            smp();
            chk($sformatf("vec%0d_csr_ready", v), 64'(csr_ready), 64'(vt[v].e_cr));
            chk($sformatf("vec%0d_alu_ready", v), 64'(alu_ready), 64'(vt[v].e_ar));
            chk($sformatf("vec%0d_hazard", v),    64'(hazard),    64'(vt[v].e_hz));
            #1;
            drop_valids();
            reg1_raddr = 0; reg2_raddr = 0;
        end

        // WAW: ALU to x3 waits for the load response, then lands right after it.
        for (int k = 0; k < 4; k++) begin
            nxt();
            alu_valid = 1; alu_waddr = 3; alu_wdata = 64'h77;
            ld_rsp_valid = (k == 2); ld_rsp_rd = 3; ld_rsp_data = 64'h55;
            if (k == 2) push(3, 64'h55);
            if (k == 3) push(3, 64'h77);
            smp();
            chk($sformatf("waw_c%0d_alu_ready", k), 64'(alu_ready), (k == 3) ? 64'd1 : 64'd0);
            if (k == 3) chk("waw_c3_wdata", reg_wdata, 64'h55);
        end
        nxt();
        drop_valids();
        smp();
        chk("waw_c4_wdata", reg_wdata, 64'h77);

        // x0 write handshakes but never reaches the register file.
        nxt();
        alu_valid = 1; alu_waddr = 0; alu_wdata = 64'hDEAD;
        smp();
        chk("x0_alu_ready", 64'(alu_ready), 1);
        nxt();
        alu_valid = 0;
        smp();
        chk("x0_reg_wen", 64'(reg_wen), 0);
        chk("pre_err_sb_err", 64'(sb_err), 0);

        // Double issue to x4 is a sticky error; x11 and x12 also outstanding before reset.
        nxt();
        ld_issue_valid = 1; ld_issue_rd = 4;
        smp();
        nxt();
        ld_issue_rd = 4;
        smp();
        chk("err_before_edge", 64'(sb_err), 0);
        nxt();
        ld_issue_rd = 11;
        smp();
        chk("err_set", 64'(sb_err), 1);
        nxt();
        ld_issue_rd = 12;
        smp();
        chk("err_sticky", 64'(sb_err), 1);
        nxt();
        ld_issue_valid = 0;
        reg1_raddr = 11; reg2_raddr = 12; alu_waddr = 4;
        smp();
        chk("pre_rst_hazard", 64'(hazard), 1);
        chk("pre_rst_alu_ready_x4", 64'(alu_ready), 0);

        // Reset mid-stream discards all outstanding loads and the error.
        nxt();
        rst = 1;
        smp();
        chk("mid_rst_csr_ready", 64'(csr_ready), 0);
        nxt();
        rst = 0;
        reg2_raddr = 4;
        smp();
        chk("post_rst_hazard", 64'(hazard), 0);
        chk("post_rst_reg_wen", 64'(reg_wen), 0);
        chk("post_rst_alu_ready_x4", 64'(alu_ready), 1);
        chk("post_rst_sb_err", 64'(sb_err), 0);

        nxt();
        smp();
        chk("exp_q_drained", 64'(exp_q.size()), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
